// File: rtl/sqrt_iter_q16_if.sv
// Handshake bundle for the iterative Q16.16 square-root unit.
// The operand enters on in_valid/in_ready/in_data. The root leaves on
// out_valid/out_ready/out_data. busy shows that an operation is in flight.
//   master: drives in_valid, in_data, out_ready (the producer/consumer side)
//   slave : drives in_ready, out_valid, out_data, busy (the sqrt unit)
interface sqrt_iter_q16_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] out_data;
  logic                 busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/sqrt_iter_q16.sv
// Iterative unsigned fixed-point square root, producing one root bit per clock.
// It uses the radix-2 digit-by-digit method. The radicand in_data * 2^FRAC_BITS
// is consumed two bits per iteration. The result has the same Q format as the
// input. The latency is fixed at ROOT_W cycles from acceptance to out_valid,
// and only one operation is in flight at a time.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low
//   bus   - sqrt_iter_q16_if.slave: in_valid/in_ready/in_data,
//           out_valid/out_ready/out_data, busy (high in CALC or DONE)
// Parameters: BIT_WIDTH, FRAC_BITS, and ROUND (0 = floor, 1 = round to nearest).
module sqrt_iter_q16 #(
  parameter int BIT_WIDTH = 32,
  parameter int FRAC_BITS = 16,
  parameter int ROUND     = 0
) (
  input  logic             clk,
  input  logic             reset,
  sqrt_iter_q16_if.slave   bus
);
  localparam int RAD_W  = BIT_WIDTH + FRAC_BITS;
  localparam int ROOT_W = RAD_W / 2;
  localparam int REM_W  = ROOT_W + 2;
  localparam int CNT_W  = $clog2(ROOT_W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  generate
    if ((RAD_W % 2) != 0) begin : g_bad_width
      $error("sqrt_iter_q16: BIT_WIDTH+FRAC_BITS must be even");
    end
    if (ROOT_W + 1 > BIT_WIDTH) begin : g_bad_frac
      $error("sqrt_iter_q16: rounded root does not fit in BIT_WIDTH");
    end
  endgenerate

  logic [1:0]           state_reg, state_next;
  logic [RAD_W-1:0]     rad_reg, rad_next;
  logic [REM_W-1:0]     rem_reg, rem_next;
  logic [ROOT_W-1:0]    root_reg, root_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [BIT_WIDTH-1:0] out_data_reg, out_data_next;

  // One iteration. The partial remainder is kept two bits wider than the
  // root, and the extra two bits of rem_s only absorb the shift. The
  // invariant rem <= 2*root keeps the truncated difference exact.
  logic [REM_W+1:0]     rem_s, trial;
  logic                 take;
  logic [REM_W-1:0]     rem_iter;
  logic [ROOT_W-1:0]    root_iter;
  logic                 round_up;
  logic [BIT_WIDTH-1:0] result;

  always_comb begin
    rem_s     = {rem_reg, rad_reg[RAD_W-1 -: 2]};
    trial     = (REM_W+2)'({root_reg, 2'b01});
    take      = (rem_s >= trial);
    rem_iter  = take ? REM_W'(rem_s - trial) : REM_W'(rem_s);
    root_iter = {root_reg[ROOT_W-2:0], take};
    // A final remainder larger than the root means that sqrt >= root + 0.5.
    round_up  = (ROUND != 0) && (rem_iter > REM_W'(root_iter));
    result    = BIT_WIDTH'(root_iter) + BIT_WIDTH'(round_up);
  end

  always_comb begin
    state_next    = state_reg;
    rad_next      = rad_reg;
    rem_next      = rem_reg;
    root_next     = root_reg;
    count_next    = count_reg;
    out_data_next = out_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid) begin
          rad_next   = {bus.in_data, {FRAC_BITS{1'b0}}};
          rem_next   = '0;
          root_next  = '0;
          count_next = CNT_W'(ROOT_W - 1);
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        rem_next  = rem_iter;
        root_next = root_iter;
        rad_next  = {rad_reg[RAD_W-3:0], 2'b00};
        if (count_reg == '0) begin
          // Latch the result once, so that it holds steady under backpressure.
          out_data_next = result;
          state_next    = ST_DONE;
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      rad_reg      <= '0;
      rem_reg      <= '0;
      root_reg     <= '0;
      count_reg    <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rad_reg      <= rad_next;
      rem_reg      <= rem_next;
      root_reg     <= root_next;
      count_reg    <= count_next;
      out_data_reg <= out_data_next;
    end
  end

  // in_ready is gated by reset, so that no operand is taken while reset is held.
  assign bus.in_ready  = reset && (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.out_data  = out_data_reg;
endmodule
